bcd_freq_counter: RTL and testbench

Frequency meter front end that measures an external digital signal and produces four BCD digits plus status flags. It sits directly upstream of the Nios II blinker system. It consumes that system's 3-bit calibration output as the gate-range select. It drives the units, tens, hundreds and thousands PIO inputs, which software reads and renders on the seven-segment displays.

---
 rtl/bcd_freq_counter_if.sv | 30 +++
 rtl/bcd_freq_counter.sv | 174 +++++++++++++++++
 tb/tb_bcd_freq_counter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_freq_counter_if.sv
// Result bus of the frequency meter: gate-range select in, four BCD digits and status out.
interface bcd_freq_counter_if;
  logic [2:0] calibration;
  logic [3:0] unites;
  logic [3:0] dizaines;
  logic [3:0] centaines;
  logic [3:0] milliers;
  logic       overflow;
  logic       valid;

  modport master (
    input  calibration,
    output unites,
    output dizaines,
    output centaines,
    output milliers,
    output overflow,
    output valid
  );

  modport slave (
    output calibration,
    input  unites,
    input  dizaines,
    input  centaines,
    input  milliers,
    input  overflow,
    input  valid
  );
endinterface

// File: rtl/bcd_freq_counter.sv
// Gated edge counter producing four BCD digits for the seven-segment PIO path.
// Optional OVF_SATURATE_EN: hold the count at 9999 on overflow instead of wrapping.
module bcd_freq_counter #(
  parameter int CLK_HZ      = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               sig_in,
  bcd_freq_counter_if.master bus
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   edge_s;
  logic [2:0]             cal_r;
  logic [TW-1:0]          timer_r;
  logic [TW-1:0]          gate_last_s;
  logic [15:0]            bcd_r;
  logic                   ovf_r;
  logic                   clear_s;
  logic                   count_s;
  logic                   latch_s;
  logic [15:0]            out_bcd_r;
  logic                   out_ovf_r;
  logic                   out_valid_r;

  // Index of the final gate cycle; unused select codes fall back to the 1 s gate.
  function automatic logic [TW-1:0] gate_last(input logic [2:0] cal);
    logic [TW-1:0] g;
    case (cal)
      3'd1:    g = TW'(CLK_HZ / 10 - 1);
      3'd2:    g = TW'(CLK_HZ / 100 - 1);
      3'd3:    g = TW'(CLK_HZ / 1000 - 1);
      default: g = TW'(CLK_HZ - 1);
    endcase
    return g;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

  assign edge_s      = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign gate_last_s = gate_last(cal_r);

  // Input synchroniser and rising-edge history flop.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Window sequencer state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_s;
    end
  end

  // Window sequencer next state and phase strobes.
  always_comb begin
    state_s = state_r;
    clear_s = 1'b0;
    count_s = 1'b0;
    latch_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clear_s = 1'b1;
        state_s = ST_GATE;
      end
      ST_GATE: begin
        count_s = 1'b1;
        if (timer_r == gate_last_s) begin
          state_s = ST_LATCH;
        end else begin
          state_s = ST_GATE;
        end
      end
      ST_LATCH: begin
        latch_s = 1'b1;
        state_s = ST_CLEAR;
      end
      default: begin
        state_s = ST_CLEAR;
      end
    endcase
  end

  // Gate timer, BCD accumulator and sticky overflow; edges outside GATE are dropped.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cal_r   <= 3'd0;
      timer_r <= {TW{1'b0}};
      bcd_r   <= 16'h0000;
      ovf_r   <= 1'b0;
    end else if (clear_s) begin
      cal_r   <= bus.calibration;
      timer_r <= {TW{1'b0}};
      bcd_r   <= 16'h0000;
      ovf_r   <= 1'b0;
    end else if (count_s) begin
      timer_r <= timer_r + TW'(1);
      if (edge_s) begin
        if (bcd_r == 16'h9999) begin
          ovf_r <= 1'b1;
`ifdef OVF_SATURATE_EN
          bcd_r <= bcd_r;
`else
          bcd_r <= 16'h0000;
`endif
        end else begin
          bcd_r <= bcd_inc(bcd_r);
        end
      end
    end
  end

  // Result registers, refreshed once per completed window.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      out_bcd_r   <= 16'h0000;
      out_ovf_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (latch_s) begin
      out_bcd_r   <= bcd_r;
      out_ovf_r   <= ovf_r;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.unites    = out_bcd_r[3:0];
  assign bus.dizaines  = out_bcd_r[7:4];
  assign bus.centaines = out_bcd_r[11:8];
  assign bus.milliers  = out_bcd_r[15:12];
  assign bus.overflow  = out_ovf_r;
  assign bus.valid     = out_valid_r;

endmodule

// File: tb/tb_bcd_freq_counter.sv
// Self-checking bench for bcd_freq_counter: window-level reference model plus literal spot checks.
module tb_bcd_freq_counter;
  localparam int CLK_HZ = 24000;
  localparam int SYNC   = 2;

  logic clk = 1'b0;
  logic reset_reset;
  logic sig_in;

  bcd_freq_counter_if bus_if ();

  bcd_freq_counter #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(SYNC)) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .sig_in      (sig_in),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pe    = 0;

  task automatic report(input string name, input int act, input string req);
    n_bad++;
    if (n_bad <= 40) $display("FAIL %s: got %0d, required %s", name, act, req);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) report(name, act, $sformatf("%0d", exp));
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) report(name, act, $sformatf("%0d +/- %0d", exp, tol));
  endtask

  function automatic int dut_val();
    return 1000 * int'(bus_if.milliers) + 100 * int'(bus_if.centaines)
         + 10 * int'(bus_if.dizaines) + int'(bus_if.unites);
  endfunction

  function automatic int gate_of(input int cal);
    case (cal)
      1:       return CLK_HZ / 10;
      2:       return CLK_HZ / 100;
      3:       return CLK_HZ / 1000;
      default: return CLK_HZ;
    endcase
  endfunction

  // Stimulus generator: 0 square wave, 1 random, 2 constant.
  int mode = 0;
  int half = 1;
  bit const_val = 1'b0;
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0: begin
          ph++;
          if (ph >= half) begin
            ph = 0;
            sig_in = ~sig_in;
          end
        end
        1:       sig_in = 1'($urandom_range(0, 1));
        default: sig_in = const_val;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    pe++;
  end

  // Reference model: cycle numbering from reset release, window = CLEAR, G gate cycles, LATCH.
  bit m_init = 1'b0;
  int m_cyc, m_ws, m_g, m_cnt;
  bit m_hist [64];
  int e_val = 0;
  bit e_ovf = 1'b0;
  bit e_valid = 1'b0;

  function automatic bit hv(input int idx);
    return (idx <= 0) ? 1'b0 : m_hist[idx % 64];
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset_reset) begin
      m_init  = 1'b1;
      m_cyc   = 1;
      m_ws    = 1;
      m_cnt   = 0;
      e_val   = 0;
      e_ovf   = 1'b0;
      e_valid = 1'b0;
    end else if (m_init) begin
      m_hist[m_cyc % 64] = sig_in;
      e_valid = 1'b0;
      if (m_cyc == m_ws) begin
        m_g   = gate_of(int'(bus_if.calibration));
        m_cnt = 0;
      end else if (m_cyc <= m_ws + m_g) begin
        if (hv(m_cyc - SYNC) && !hv(m_cyc - SYNC - 1)) m_cnt++;
      end else begin
`ifdef OVF_SATURATE_EN
        e_val = (m_cnt > 9999) ? 9999 : m_cnt;
`else
        e_val = m_cnt % 10000;
`endif
        e_ovf   = (m_cnt > 9999);
        e_valid = 1'b1;
        m_ws    = m_cyc + 1;
      end
      m_cyc++;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(posedge clk);
    #1;
    if (m_init) begin
      check("valid", int'(bus_if.valid), int'(e_valid));
      check("digits", dut_val(), e_val);
      check("overflow", int'(bus_if.overflow), int'(e_ovf));
    end
  end

  task automatic wait_valid(input int budget, input string name, output int at);
    bit seen;
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.valid === 1'b1) begin
        seen = 1'b1;
        at = pe;
      end
    end
    if (!seen) begin
      n_cmp++;
      report({name, "_timeout"}, budget, "a valid pulse within budget");
    end
  endtask

  initial begin
    int t_rel, t_v, t_prev, cal;
    reset_reset = 1'b1;
    bus_if.calibration = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(bus_if.valid), 0);
    check("reset_digits", dut_val(), 0);
    check("reset_ovf", int'(bus_if.overflow), 0);
    reset_reset = 1'b0;
    t_rel = pe;

    // Window 1: 1 s gate, period-2 input (12000 edges), calibration change mid-window.
    repeat (12000) @(negedge clk);
    bus_if.calibration = 3'd1;
    wait_valid(CLK_HZ + 100, "w1", t_v);
    check("w1_latency", t_v - t_rel, CLK_HZ + 2);
    check("w1_ovf", int'(bus_if.overflow), 1);
`ifdef OVF_SATURATE_EN
    check("w1_sat_digits", dut_val(), 9999);
`else
    check_near("w1_wrap_digits", dut_val(), 2000, 1);
`endif

    // Window 2: the new select is in force, period 8.
    half = 4;
    t_prev = t_v;
    wait_valid(3000, "w2", t_v);
    check("w2_spacing", t_v - t_prev, 2402);
    check_near("w2_digits", dut_val(), 300, 3);
    check("w2_ovf", int'(bus_if.overflow), 0);

    bus_if.calibration = 3'd3;
    for (int k = 0; k < 5; k++) begin
      t_prev = t_v;
      wait_valid(100, "cal3", t_v);
      check("cal3_spacing", t_v - t_prev, 26);
      check_near("cal3_digits", dut_val(), 3, 1);
    end

    mode = 1;
    bus_if.calibration = 3'd2;
    for (int k = 0; k < 8; k++) begin
      t_prev = t_v;
      wait_valid(300, "rand_cal2", t_v);
      check("cal2_spacing", t_v - t_prev, 242);
    end

    bus_if.calibration = 3'($urandom_range(4, 7));
    t_prev = t_v;
    wait_valid(CLK_HZ + 100, "cal_hi", t_v);
    check("cal_hi_spacing", t_v - t_prev, CLK_HZ + 2);

    for (int k = 0; k < 6; k++) begin
      cal = $urandom_range(1, 3);
      bus_if.calibration = 3'(cal);
      t_prev = t_v;
      wait_valid(3000, "rand_cal", t_v);
      check("rand_cal_spacing", t_v - t_prev, gate_of(cal) + 2);
    end

    // Constant-high input: no edges, windows keep running.
    mode = 2;
    const_val = 1'b1;
    bus_if.calibration = 3'd3;
    for (int k = 0; k < 3; k++) begin
      t_prev = t_v;
      wait_valid(100, "const", t_v);
      check("const_spacing", t_v - t_prev, 26);
      if (k > 0) begin
        check("const_digits", dut_val(), 0);
        check("const_ovf", int'(bus_if.overflow), 0);
      end
    end

    // Reset pulse mid-window aborts it and restarts the timeline.
    mode = 0;
    half = 4;
    bus_if.calibration = 3'd1;
    t_prev = t_v;
    wait_valid(3000, "pre_rst", t_v);
    check("pre_rst_spacing", t_v - t_prev, 2402);
    check_near("pre_rst_digits", dut_val(), 300, 2);
    repeat (1200) @(negedge clk);
    reset_reset = 1'b1;
    @(negedge clk);
    reset_reset = 1'b0;
    t_rel = pe;
    check("rst_pulse_valid", int'(bus_if.valid), 0);
    check("rst_pulse_digits", dut_val(), 0);
    check("rst_pulse_ovf", int'(bus_if.overflow), 0);
    wait_valid(2600, "post_rst", t_v);
    check("post_rst_latency", t_v - t_rel, 2402);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
